// File: rtl/scroll_scheduler_if.sv
// Bundle of the frame-rate control inputs and the scroll outputs exchanged
// between the scroll scheduler and its surroundings (switch logic, renderer).
interface scroll_scheduler_if #(
  parameter int SPEED_W = 4
);
  logic               frame_tick;
  logic [SPEED_W-1:0] target_speed;
  logic               dir;
  logic               pause;
  logic               step_req;
  logic [9:0]         x_offset;
  logic [SPEED_W-1:0] cur_speed;
  logic               cur_dir;
  logic               running;
  logic               paused;
  logic               update_strobe;

  // Driver side: produces the frame tick and user requests, consumes the scroll state
  modport master (
    output frame_tick, target_speed, dir, pause, step_req,
    input  x_offset, cur_speed, cur_dir, running, paused, update_strobe
  );

  // Scheduler side
  modport slave (
    input  frame_tick, target_speed, dir, pause, step_req,
    output x_offset, cur_speed, cur_dir, running, paused, update_strobe
  );
endinterface

// File: rtl/scroll_scheduler.sv
// Frame-rate sequencer for the scrolling sine-wave scene. Once per frame tick
// it ramps the scroll speed toward the requested target, brakes to zero before
// reversing, and supports pause with single-pixel stepping. All outputs are
// registered and only move in the cycle after a frame tick, so the renderer
// sees a stable offset for the whole visible frame.
module scroll_scheduler #(
  parameter int WRAP        = 400,
  parameter int SPEED_W     = 4,
  parameter int RAMP_FRAMES = 4
) (
  input  logic               clk,
  input  logic               reset,
  scroll_scheduler_if.slave  bus
);

  localparam int          RAMP_W    = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_FRAMES - 1);
  localparam logic [10:0] WRAP_11   = 11'(WRAP);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [9:0]         x_offset;
  logic [SPEED_W-1:0] cur_speed;
  logic               cur_dir;
  logic               running;
  logic               paused;
  logic               update_strobe;
  logic [RAMP_W-1:0]  ramp_cnt;
  logic               step_pending;

  logic [9:0]         x_offset_next;
  logic [SPEED_W-1:0] cur_speed_next;
  logic               cur_dir_next;
  logic               running_next;
  logic               paused_next;
  logic [RAMP_W-1:0]  ramp_cnt_next;
  logic [SPEED_W-1:0] eff_target;

  // Move an offset by amt pixels in the given direction, folding back into
  // 0..WRAP-1. One correction suffices because amt is always below WRAP; the
  // 11-bit intermediate keeps the sign of a reverse underflow in bit 10.
  function automatic logic [9:0] wrap_move(input logic [9:0]         x,
                                           input logic [SPEED_W-1:0] amt,
                                           input logic               rev);
    logic [10:0] t;
    if (!rev) begin
      t = {1'b0, x} + 11'(amt);
      if (t >= WRAP_11) t = t - WRAP_11;
    end else begin
      t = {1'b0, x} - 11'(amt);
      if (t[10]) t = t + WRAP_11;
    end
    return 10'(t);
  endfunction

  // State register; only frame ticks advance the sequencer
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_INIT;
    end else if (bus.frame_tick) begin
      state <= state_next;
    end
  end

  // Next-state decision evaluated for the coming frame tick
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT:   state_next = ST_RUN;
      ST_RUN:    if (bus.pause && (cur_speed == '0)) state_next = ST_PAUSED;
      ST_PAUSED: if (!bus.pause) state_next = ST_RUN;
      default:   state_next = ST_INIT;
    endcase
  end

  // Per-frame datapath update: offset advance, speed ramp, direction and pause flags
  always_comb begin
    x_offset_next  = x_offset;
    cur_speed_next = cur_speed;
    cur_dir_next   = cur_dir;
    running_next   = running;
    paused_next    = paused;
    ramp_cnt_next  = ramp_cnt;
    eff_target     = (bus.pause || (bus.dir != cur_dir)) ? '0 : bus.target_speed;
    case (state)
      ST_INIT: begin
        running_next = 1'b1;
      end
      ST_RUN: begin
        x_offset_next = wrap_move(x_offset, cur_speed, cur_dir);
        if ((cur_speed == '0) && (bus.dir != cur_dir)) begin
          cur_dir_next  = bus.dir;
          ramp_cnt_next = '0;
        end else if (cur_speed == eff_target) begin
          ramp_cnt_next = '0;
        end else if (ramp_cnt == RAMP_LAST) begin
          cur_speed_next = (cur_speed < eff_target) ? cur_speed + SPEED_W'(1)
                                                    : cur_speed - SPEED_W'(1);
          ramp_cnt_next  = '0;
        end else begin
          ramp_cnt_next = ramp_cnt + RAMP_W'(1);
        end
        if (bus.pause && (cur_speed == '0)) paused_next = 1'b1;
      end
      ST_PAUSED: begin
        cur_dir_next   = bus.dir;
        cur_speed_next = '0;
        if (!bus.pause) begin
          paused_next   = 1'b0;
          ramp_cnt_next = '0;
        end else if (step_pending || bus.step_req) begin
          x_offset_next = wrap_move(x_offset, SPEED_W'(1), cur_dir);
        end
      end
      default: begin
        x_offset_next = x_offset;
      end
    endcase
  end

  // Datapath registers; step requests are latched between ticks while paused
  always_ff @(posedge clk) begin
    if (reset) begin
      x_offset      <= '0;
      cur_speed     <= '0;
      cur_dir       <= 1'b0;
      running       <= 1'b0;
      paused        <= 1'b0;
      update_strobe <= 1'b0;
      ramp_cnt      <= '0;
      step_pending  <= 1'b0;
    end else begin
      update_strobe <= bus.frame_tick && (state != ST_INIT);
      if (bus.frame_tick) begin
        x_offset     <= x_offset_next;
        cur_speed    <= cur_speed_next;
        cur_dir      <= cur_dir_next;
        running      <= running_next;
        paused       <= paused_next;
        ramp_cnt     <= ramp_cnt_next;
        step_pending <= 1'b0;
      end else if ((state == ST_PAUSED) && bus.step_req) begin
        step_pending <= 1'b1;
      end
    end
  end

  assign bus.x_offset      = x_offset;
  assign bus.cur_speed     = cur_speed;
  assign bus.cur_dir       = cur_dir;
  assign bus.running       = running;
  assign bus.paused        = paused;
  assign bus.update_strobe = update_strobe;

endmodule

// File: tb/tb_scroll_scheduler.sv
// Directed test of the scroll scheduler: ramp-up, forward and reverse wrap,
// braking before reversal, pause with stepping, and reset on a tick.
module tb_scroll_scheduler;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   exp_off;

  scroll_scheduler_if #(.SPEED_W(4)) bus ();

  scroll_scheduler #(
    .WRAP(400),
    .SPEED_W(4),
    .RAMP_FRAMES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  // Free-running pixel clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] tgt, input logic d, input logic p);
    bus.target_speed = tgt;
    bus.dir          = d;
    bus.pause        = p;
  endtask

  task automatic checkState(input string tag, input int off, input int spd, input int cdir);
    checkOutput({tag, "_off"}, 32'(bus.x_offset), off);
    checkOutput({tag, "_spd"}, 32'(bus.cur_speed), spd);
    checkOutput({tag, "_dir"}, 32'(bus.cur_dir), cdir);
  endtask

  // One frame: a one-cycle tick, then strobe must be up for one cycle only
  task automatic frameTick(input logic exp_strobe, input logic with_step = 1'b0);
    @(negedge clk);
    bus.frame_tick = 1'b1;
    bus.step_req   = with_step;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    bus.step_req   = 1'b0;
    checkOutput("strobe_hi", 32'(bus.update_strobe), 32'(exp_strobe));
    @(negedge clk);
    checkOutput("strobe_lo", 32'(bus.update_strobe), 0);
    @(negedge clk);
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) frameTick(1'b1);
  endtask

  task automatic pulseStep();
    @(negedge clk);
    bus.step_req = 1'b1;
    @(negedge clk);
    bus.step_req = 1'b0;
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    reset          = 1'b1;
    bus.frame_tick = 1'b0;
    bus.step_req   = 1'b0;
    applyStimulus(4'd8, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkState("rst", 0, 0, 0);
    checkOutput("rst_running", 32'(bus.running), 0);
    checkOutput("rst_paused", 32'(bus.paused), 0);
    checkOutput("rst_strobe", 32'(bus.update_strobe), 0);
    reset = 1'b0;

    // First tick only leaves INIT
    frameTick(1'b0);
    checkOutput("init_running", 32'(bus.running), 1);
    checkState("init", 0, 0, 0);
    runTicks(3);
    checkState("t4", 0, 0, 0);
    frameTick(1'b1);
    checkState("t5", 0, 1, 0);
    runTicks(28);
    checkState("t33", 112, 8, 0);
    frameTick(1'b1);
    checkState("t34", 120, 8, 0);

    // Forward wrap at full speed, passing exactly 392 -> 0
    exp_off = 120;
    for (int i = 0; i < 36; i++) begin
      frameTick(1'b1);
      exp_off = (exp_off + 8) % 400;
      checkOutput("wrap_fwd", 32'(bus.x_offset), exp_off);
      checkOutput("below_wrap", 32'(bus.x_offset < 10'd400), 1);
    end
    checkState("t70", 8, 8, 0);

    // Reset coincident with a frame tick in RUN dominates
    @(negedge clk);
    reset          = 1'b1;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    checkState("rst_tick", 0, 0, 0);
    checkOutput("rst_tick_running", 32'(bus.running), 0);
    checkOutput("rst_tick_strobe", 32'(bus.update_strobe), 0);
    reset = 1'b0;

    // Ramp to 3, then request reverse: brake, flip, ramp back up
    applyStimulus(4'd3, 1'b0, 1'b0);
    frameTick(1'b0);
    checkOutput("init2_running", 32'(bus.running), 1);
    runTicks(12);
    checkState("r13", 12, 3, 0);
    frameTick(1'b1);
    checkState("r14", 15, 3, 0);
    applyStimulus(4'd3, 1'b1, 1'b0);
    runTicks(4);
    checkState("r18", 27, 2, 0);
    runTicks(4);
    checkState("r22", 35, 1, 0);
    runTicks(4);
    checkState("r26", 39, 0, 0);
    frameTick(1'b1);
    checkState("r27_flip", 39, 0, 1);
    runTicks(4);
    checkState("r31", 39, 1, 1);
    runTicks(4);
    checkState("r35", 35, 2, 1);
    runTicks(4);
    checkState("r39", 27, 3, 1);

    // Reverse wrap through exactly 0 then below zero
    exp_off = 27;
    for (int i = 0; i < 10; i++) begin
      frameTick(1'b1);
      exp_off = (exp_off + 400 - 3) % 400;
      checkOutput("wrap_rev", 32'(bus.x_offset), exp_off);
    end
    checkState("r49", 397, 3, 1);

    // Pause: decelerate to zero, then enter PAUSED one tick later
    applyStimulus(4'd3, 1'b1, 1'b1);
    runTicks(4);
    checkState("p53", 385, 2, 1);
    runTicks(8);
    checkState("p61", 373, 0, 1);
    checkOutput("p61_paused", 32'(bus.paused), 0);
    frameTick(1'b1);
    checkOutput("p62_paused", 32'(bus.paused), 1);
    checkState("p62", 373, 0, 1);

    // Direction change while paused, no step requested
    applyStimulus(4'd3, 1'b0, 1'b1);
    frameTick(1'b1);
    checkState("p63", 373, 0, 0);

    // Two requests in one frame merge into a single step
    pulseStep();
    pulseStep();
    frameTick(1'b1);
    checkState("p64_step", 374, 0, 0);
    frameTick(1'b1);
    checkState("p65_nostep", 374, 0, 0);

    // Request coincident with the tick counts for that frame
    frameTick(1'b1, 1'b1);
    checkState("p66_cotick", 375, 0, 0);
    frameTick(1'b1);
    checkState("p67", 375, 0, 0);

    // Reverse step uses the applied direction
    applyStimulus(4'd3, 1'b1, 1'b1);
    frameTick(1'b1);
    checkState("p68", 375, 0, 1);
    frameTick(1'b1, 1'b1);
    checkState("p69_revstep", 374, 0, 1);

    // Release pause: pending step is dropped, speed ramps from zero
    pulseStep();
    applyStimulus(4'd3, 1'b1, 1'b0);
    frameTick(1'b1);
    checkState("p70_resume", 374, 0, 1);
    checkOutput("p70_paused", 32'(bus.paused), 0);
    runTicks(4);
    checkState("p74", 374, 1, 1);
    frameTick(1'b1);
    checkState("p75", 373, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scroll_scheduler.md
Name: scroll_scheduler

Overview:
Frame-rate sequencer for the scrolling sine-wave scene. It runs in the pixel clock domain and takes a one-cycle frame tick at the start of vertical blank. It replaces direct vsync-clocked sampling of the switches. It ramps scroll speed toward a user target, decelerates to zero before any direction reversal, and supports pause with single-frame stepping. It produces a tear-free, modulo-WRAP horizontal offset for the wave renderer and the player-following logic.

Parameters:
WRAP, 400, offset modulus (ten 40-px bars); must exceed 2^SPEED_W.
SPEED_W, 4, width of speed values.
RAMP_FRAMES, 4, frame ticks per one-unit speed change; must be at least 1.

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high
frame_tick  in  1  one-cycle pulse at v_count==480, h_count==0
target_speed  in  SPEED_W  requested speed, px/frame
dir  in  1  requested direction; 0 = forward (+), 1 = reverse (-)
pause  in  1  level; request to stop scrolling
step_req  in  1  pulse; request a one-pixel advance while paused
x_offset  out  10  scroll offset, 0..WRAP-1, registered
cur_speed  out  SPEED_W  applied speed, registered
cur_dir  out  1  applied direction, registered
running  out  1  high once the first frame has been processed; gates the player
paused  out  1  high in the PAUSED state
update_strobe  out  1  one-cycle pulse the cycle after each processed frame_tick in RUN or PAUSED

Behaviour:
- Reset values: x_offset=0, cur_speed=0, cur_dir=0, running=0, paused=0, update_strobe=0, ramp_cnt=0, step_pending=0, state=INIT.
- Reset dominates every other input in the same cycle. Reset mid-ramp or mid-pause returns all state to the reset values.
- All state changes occur only on frame_tick cycles, except step_pending capture. Outputs are registered and change in the cycle after frame_tick, then hold for the rest of the frame.
- States: INIT, RUN, PAUSED.
- INIT: on frame_tick go to RUN and set running=1. There is no offset update and no update_strobe on this tick.
- RUN, on each frame_tick, in order:
  - Offset: computed from the pre-tick cur_speed and cur_dir. Forward: x_offset+cur_speed, subtract WRAP if the result is >= WRAP. Reverse: x_offset-cur_speed, add WRAP if the result is negative. Use an 11-bit intermediate. Exactly one correction is enough because cur_speed < WRAP.
  - Effective target: 0 if pause==1 or dir!=cur_dir; otherwise target_speed.
  - Direction flip: if cur_speed==0 and dir!=cur_dir, set cur_dir<=dir and ramp_cnt<=0 immediately, with no ramp wait.
  - Speed already at target: if cur_speed==eff_target, set ramp_cnt<=0.
  - Speed ramping, with ramp_cnt==RAMP_FRAMES-1: cur_speed moves one unit toward eff_target and ramp_cnt<=0.
  - Speed ramping, otherwise: ramp_cnt increments.
  - Enter PAUSED: if pause==1 and the pre-tick cur_speed==0, set paused=1.
- PAUSED, on frame_tick:
  - If pause==0: go to RUN, set paused=0, ramp_cnt=0; speed ramps up from 0 on following ticks.
  - Else if step_pending or step_req: x_offset advances by exactly 1 in cur_dir with wrap, and step_pending clears.
  - cur_speed stays 0 in PAUSED.
  - A dir change in PAUSED sets cur_dir<=dir on the tick.
- step_pending:
  - Set by step_req in any cycle while in PAUSED. A step_req coincident with frame_tick counts for that frame.
  - Multiple requests within one frame merge into one step.
  - Cleared on every frame_tick, and on leaving PAUSED; step_req in RUN or INIT is ignored.
- update_strobe pulses in the cycle after every frame_tick processed in RUN or PAUSED, including ticks where nothing changes.
- target_speed changes mid-ramp retarget on the next step without resetting ramp_cnt.
- A missing frame_tick freezes all state.

Test Plan:
1. Reset, then first tick with target_speed=8, dir=0 -> running=1, x_offset=0, cur_speed=0. Ticks 2-5 -> cur_speed=1 after tick 5. cur_speed=8 after tick 33, then x_offset grows by 8 per tick.
2. Wrap: reach cur_speed=8, cur_dir=0 with x_offset=396 -> next tick x_offset=4. With cur_speed=5, cur_dir=1, x_offset=3 -> next tick x_offset=398. Check over 200 ticks that x_offset never reaches 400.
3. Reversal: at cur_speed=3, cur_dir=0, set dir=1 -> speed steps 3,2,1,0 at 4-tick intervals with cur_dir=0 throughout. The tick after reaching 0 sets cur_dir=1, then speed ramps to target. No offset jump larger than the pre-tick speed on any tick.
4. Pause/step: at cur_speed=2, assert pause -> decelerates to 0 over 8 ticks, paused=1 on the following tick. Pulse step_req twice within one frame at x_offset=100, cur_dir=0 -> x_offset=101 after the next tick only; no further advance without new requests. Deassert pause -> paused=0, speed ramps from 0.
5. Simultaneous events: step_req on the same cycle as frame_tick in PAUSED -> step taken that frame. Reset asserted on a frame_tick cycle in RUN -> all outputs at reset values next cycle, state INIT.
6. Strobe/tear-free: check that x_offset and cur_speed change only in the cycle after frame_tick. update_strobe is high for exactly 1 cycle per processed tick and absent on the INIT tick.
